// File: rtl/alu_sched_pkg.sv
// Shared definitions for alu_op_scheduler: FSM state encoding, op indices and
// the op-index to one-hot op_code mapping used by ascii_alu.
package alu_sched_pkg;

    localparam int NUM_OPS = 9;
    localparam int OP_W    = 11;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CHECK = 3'd1;
    localparam logic [2:0] ST_ISSUE = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_HOLD  = 3'd4;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_MUL = 4'd2,
        OP_DIV = 4'd3,
        OP_AND = 4'd4,
        OP_OR  = 4'd5,
        OP_XOR = 4'd6,
        OP_NOT = 4'd7,
        OP_RXN = 4'd8
    } op_e;

    // Legality against NUM_OPS is decided by the caller.
    function automatic logic [OP_W-1:0] op_to_onehot(input logic [3:0] op);
        return {{(OP_W-1){1'b0}}, 1'b1} << op;
    endfunction

endpackage

// File: rtl/alu_sched_if.sv
// Requester handshakes, ascii_alu bus and response strobe of alu_op_scheduler.
// master = surrounding system (requesters + ALU), slave = the scheduler.
interface alu_sched_if #(
    parameter int DATA_W = 8,
    parameter int OP_W   = 11
);
    logic              req0_valid;
    logic [3:0]        req0_op;
    logic [DATA_W-1:0] req0_a;
    logic [DATA_W-1:0] req0_b;
    logic              req0_ready;

    logic              req1_valid;
    logic [3:0]        req1_op;
    logic [DATA_W-1:0] req1_a;
    logic [DATA_W-1:0] req1_b;
    logic              req1_ready;

    logic [OP_W-1:0]   alu_op_code;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic              alu_go;
    logic              alu_done;

    logic              rsp_valid;
    logic              rsp_id;
    logic              rsp_err;
    logic              busy;

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        output alu_done,
        input  req0_ready, req1_ready,
        input  alu_op_code, alu_a, alu_b, alu_go,
        input  rsp_valid, rsp_id, rsp_err, busy
    );

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        input  alu_done,
        output req0_ready, req1_ready,
        output alu_op_code, alu_a, alu_b, alu_go,
        output rsp_valid, rsp_id, rsp_err, busy
    );
endinterface

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter; the pointer flips to the other port
// whenever a grant is taken (i_advance).
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] i_req,
    input  logic       i_advance,
    output logic [1:0] o_grant
);
    logic r_ptr;

    always_comb begin
        case (i_req)
            2'b01:   o_grant = 2'b01;
            2'b10:   o_grant = 2'b10;
            2'b11:   o_grant = r_ptr ? 2'b10 : 2'b01;
            default: o_grant = 2'b00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= 1'b0;
        end else if (i_advance && (o_grant != 2'b00)) begin
            r_ptr <= ~o_grant[1];
        end
    end
endmodule

// File: rtl/alu_op_scheduler.sv
// Shares ascii_alu between two requesters: arbitrate, check op, issue go, wait for done, hold result.
// Optional watchdog in WAIT is enabled by defining ALU_SCHED_WDOG_EN.
module alu_op_scheduler #(
    parameter int DATA_W      = 8,
    parameter int OP_W        = alu_sched_pkg::OP_W,
    parameter int NUM_OPS     = alu_sched_pkg::NUM_OPS,
    parameter int HOLD_CYCLES = 16,
    parameter int WDOG_CYCLES = 1024
) (
    input logic        clk,
    input logic        reset,
    alu_sched_if.slave bus
);
    import alu_sched_pkg::*;

    localparam int CNT_MAX = (HOLD_CYCLES > WDOG_CYCLES) ? HOLD_CYCLES : WDOG_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    logic [2:0]        r_state;
    logic              r_owner;
    logic [3:0]        r_op;
    logic [OP_W-1:0]   r_op_code;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_done_d;
    logic              r_rsp_valid;
    logic              r_rsp_err;
    logic              r_rsp_id;

    logic [1:0]        w_grant;
    logic              w_accept;
    logic              w_done_rise;
    logic              w_sel_legal;
    logic [3:0]        w_sel_op;
    logic [DATA_W-1:0] w_sel_a;
    logic [DATA_W-1:0] w_sel_b;

    rr_arbiter2 u_arb (
        .clk       (clk),
        .reset     (reset),
        .i_req     ({bus.req1_valid, bus.req0_valid}),
        .i_advance (w_accept),
        .o_grant   (w_grant)
    );

    assign w_accept    = (r_state == ST_IDLE) && (w_grant != 2'b00);
    assign w_sel_op    = w_grant[1] ? bus.req1_op : bus.req0_op;
    assign w_sel_a     = w_grant[1] ? bus.req1_a  : bus.req0_a;
    assign w_sel_b     = w_grant[1] ? bus.req1_b  : bus.req0_b;
    assign w_sel_legal = 32'(w_sel_op) < NUM_OPS;
    assign w_done_rise = bus.alu_done && !r_done_d;

    assign bus.req0_ready  = w_accept && w_grant[0];
    assign bus.req1_ready  = w_accept && w_grant[1];
    assign bus.alu_op_code = r_op_code;
    assign bus.alu_a       = r_a;
    assign bus.alu_b       = r_b;
    assign bus.alu_go      = (r_state == ST_ISSUE);
    assign bus.rsp_valid   = r_rsp_valid;
    assign bus.rsp_err     = r_rsp_err;
    assign bus.rsp_id      = r_rsp_id;
    assign bus.busy        = (r_state != ST_IDLE);

    // Op code and operands load on the accept edge so they are stable one cycle before go.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_owner     <= 1'b0;
            r_op        <= '0;
            r_op_code   <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_cnt       <= '0;
            r_done_d    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_id    <= 1'b0;
        end else begin
            r_done_d    <= bus.alu_done;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_owner   <= w_grant[1];
                        r_op      <= w_sel_op;
                        r_op_code <= w_sel_legal ? OP_W'(op_to_onehot(w_sel_op)) : '0;
                        r_a       <= w_sel_a;
                        r_b       <= w_sel_b;
                        r_state   <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    r_cnt <= '0;
                    if (32'(r_op) >= NUM_OPS) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b1;
                        r_rsp_id    <= r_owner;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_cnt   <= r_cnt + 1'b1;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Watchdog counts from go, so expiry lands WDOG_CYCLES after go.
                    if (w_done_rise) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_id    <= r_owner;
                        r_cnt       <= '0;
                        r_state     <= ST_HOLD;
`ifdef ALU_SCHED_WDOG_EN
                    end else if (r_cnt == CNT_W'(WDOG_CYCLES - 1)) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b1;
                        r_rsp_id    <= r_owner;
                        r_op_code   <= '0;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
`endif
                    end
                end
                ST_HOLD: begin
                    if (r_cnt == CNT_W'(HOLD_CYCLES - 1)) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: doc/alu_op_scheduler.md
Name: alu_op_scheduler

Overview:
- Sequences and shares the ascii_alu datapath between two requesters: the switch panel (port 0) and an auxiliary command source such as a keypad or UART decoder (port 1).
- Accepts compact 4-bit op requests with 8-bit operands, arbitrates round-robin, and converts the op to the 11-bit one-hot op_code.
- Drives operands and a single-cycle go pulse, waits for completion, then holds the result for display and reports the response to the granted requester.
- Sits between the input_output top level and ascii_alu.

Parameters:
- DATA_W, 8, operand width for a and b.
- OP_W, 11, width of the one-hot op_code.
- NUM_OPS, 9, count of legal op indices (0..8); indices at or above NUM_OPS are illegal.
- HOLD_CYCLES, 16, cycles the grant and operands are held after done before the next arbitration.
- WDOG_CYCLES, 1024, watchdog limit in WAIT (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has a command.
- req0_op  in  4  requester 0 op index (0=add … 8=rxn).
- req0_a, req0_b  in  DATA_W  requester 0 operands.
- req0_ready  out  1  command accepted this cycle (valid&&ready handshake).
- req1_valid, req1_op, req1_a, req1_b, req1_ready: same as port 0, for requester 1.
- alu_op_code  out  OP_W  one-hot op to ascii_alu.
- alu_a, alu_b  out  DATA_W  operands to ascii_alu.
- alu_go  out  1  single-cycle start pulse.
- alu_done  in  1  ALU completion strobe; may be held high.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_id  out  1  requester that owned the completed command.
- rsp_err  out  1  with rsp_valid: illegal op or watchdog expiry.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset, applied synchronously on any clk edge where reset=1 and taking priority in every state:
  - state goes to IDLE.
  - All outputs are 0, including alu_op_code=0.
  - The round-robin pointer selects port 0 first.
  - Any command in flight is abandoned; no rsp_valid is issued for it.
- IDLE:
  - If exactly one reqN_valid is high, that port is granted.
  - If both are high, the port the pointer selects is granted.
  - The pointer then moves to the other port, so a requester that keeps asserting cannot starve the other.
  - reqN_ready pulses for one cycle with the grant. Op and operands are latched on that edge.
  - The next state is CHECK.
  - A ready pulse is never given to a port whose valid is low.
- CHECK (1 cycle):
  - If the latched op ≥ NUM_OPS: rsp_valid=1, rsp_err=1 next cycle, then IDLE. No go is issued and alu_op_code stays 0.
  - Otherwise alu_op_code=1<<op and alu_a/alu_b take the latched operands, then ISSUE.
- ISSUE (1 cycle): alu_go=1, then WAIT.
  - Accept-to-go latency is 2 cycles.
  - Operands and op_code are stable from one cycle before go until HOLD exits.
- WAIT:
  - alu_done is rising-edge detected internally, so a done left high from an earlier command is ignored.
  - The first rising edge moves to HOLD and pulses rsp_valid=1, rsp_err=0 with rsp_id=owner.
- HOLD:
  - Counts HOLD_CYCLES while op_code and operands remain driven, so the display stays valid.
  - Then IDLE.
  - alu_op_code stays at its last value in IDLE until the next grant, so the display persists.
- Simultaneous events:
  - A request that arrives during CHECK, ISSUE, WAIT or HOLD gets ready=0 and waits; valid must be held until ready.
  - alu_done in the same cycle as go is ignored, because edge detection starts in WAIT.
- Widths: operands pass through unchanged. The op index is compared unsigned.

Optional Feature:
- ALU_SCHED_WDOG_EN defined:
  - A counter runs in WAIT.
  - After WDOG_CYCLES cycles with no done edge: rsp_valid=1, rsp_err=1, alu_op_code cleared to 0, then IDLE with no HOLD.
- Not defined: WAIT lasts indefinitely until done, and WDOG_CYCLES is unused.

Decomposition:
- Shared package alu_sched_pkg holds:
  - state encoding: IDLE, CHECK, ISSUE, WAIT, HOLD;
  - op index constants OP_ADD=0 … OP_RXN=8;
  - NUM_OPS, OP_W;
  - a function mapping an op index to its one-hot code.
- One sub-module, rr_arbiter2: a 2-requester round-robin arbiter with a grant-advance input.
- The FSM, latches and counters stay in the top module.

Test Plan:
- Single request: req0 op=0, a=3, b=4.
  - req0_ready pulses in cycle 1 and alu_go in cycle 3, with alu_op_code=11'b00000000001, alu_a=3, alu_b=4.
  - After done, rsp_valid=1, rsp_id=0, rsp_err=0.
  - busy stays high for HOLD_CYCLES more cycles.
- Contention: req0 and req1 both valid, then re-asserted.
  - Grants alternate 0,1,0,1.
  - After 4 completions each port has exactly 2 responses.
- Illegal op: req1 op=12.
  - rsp_valid with rsp_err=1 and rsp_id=1, 2 cycles after accept.
  - alu_go is never asserted and alu_op_code stays 0.
- Done held high: alu_done stays 1 across two commands.
  - The second command does not complete until done drops and rises again.
- Reset mid-WAIT: reset asserted for 1 cycle during WAIT.
  - Next cycle busy=0, all outputs 0, no rsp_valid.
  - With both requests pending, port 0 is granted first.
- Watchdog (ALU_SCHED_WDOG_EN, WDOG_CYCLES=8): no done.
  - rsp_err=1 exactly 8 cycles after go.
  - alu_op_code returns to 0, then IDLE.
